// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
// Serialises instruction-fetch (IMEM, 16-bit flash) and data (DMEM, 8-bit PSRAM)
// requests onto a one-transaction-at-a-time SPI memory controller, DMEM first,
// and routes read data back. A one-entry instruction buffer answers repeat
// fetches of the same word without going to SPI.
//
// Ports
//   clk_in, reset_in                   clock, synchronous active-high reset
//   imem_req_in/addr_in                fetch request (held until ack), byte address
//   imem_ack_out/data_out              one-cycle completion pulse, fetched word (held)
//   dmem_req_in/we_in/addr_in/wdata_in data request (held until ack)
//   dmem_ack_out/rdata_out             one-cycle completion pulse, read byte (held)
//   ctrl_addr_out/addr_valid_out       request to controller, valid is a 1-cycle pulse
//   ctrl_mem_type_out/wdata_out        transaction type and write byte
//   ctrl_flash_data_in/psram_data_in   read data from controller
//   ctrl_busy_in                       controller busy; falling edge marks data valid

package mem_request_arbiter_pkg;
  typedef enum logic [1:0] {
    TYPE_IMEM_READ  = 2'd0,
    TYPE_DMEM_READ  = 2'd1,
    TYPE_DMEM_WRITE = 2'd2
  } mem_type_t;
endpackage

module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int unsigned IBUF_EN = 1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        imem_req_in,
  input  logic [15:0] imem_addr_in,
  output logic        imem_ack_out,
  output logic [15:0] imem_data_out,
  input  logic        dmem_req_in,
  input  logic        dmem_we_in,
  input  logic [15:0] dmem_addr_in,
  input  logic [7:0]  dmem_wdata_in,
  output logic        dmem_ack_out,
  output logic [7:0]  dmem_rdata_out,
  output logic [15:0] ctrl_addr_out,
  output logic        ctrl_addr_valid_out,
  output mem_type_t   ctrl_mem_type_out,
  output logic [7:0]  ctrl_wdata_out,
  input  logic [15:0] ctrl_flash_data_in,
  input  logic [7:0]  ctrl_psram_data_in,
  input  logic        ctrl_busy_in
);

  localparam bit UseIbuf = (IBUF_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t      state, state_next;

  logic [15:0] lat_addr;
  mem_type_t   lat_type;
  logic [7:0]  lat_wdata;

  logic        ibuf_valid;
  logic [14:0] ibuf_tag;
  logic [15:0] ibuf_data;
  logic        ibuf_hit;

  logic        take_dmem;
  logic        take_hit;
  logic        take_miss;
  logic        capture;

  // Fetches are word-aligned; the byte-select bit carries no information.
  logic        addr_lsb_unused;
  assign addr_lsb_unused = imem_addr_in[0];

  assign ibuf_hit = UseIbuf && ibuf_valid && (ibuf_tag == imem_addr_in[15:1]);

  // The latched request registers drive the controller directly, so they stay
  // stable from ISSUE until the next request is latched.
  assign ctrl_addr_out       = lat_addr;
  assign ctrl_mem_type_out   = lat_type;
  assign ctrl_wdata_out      = lat_wdata;
  assign ctrl_addr_valid_out = (state == ISSUE);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take_dmem  = 1'b0;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // A port acked this cycle still shows its old request; skip it.
        if (!ctrl_busy_in) begin
          if (dmem_req_in && !dmem_ack_out) begin
            take_dmem  = 1'b1;
            state_next = ISSUE;
          end else if (imem_req_in && !imem_ack_out) begin
            if (ibuf_hit) begin
              take_hit = 1'b1;
            end else begin
              take_miss  = 1'b1;
              state_next = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ctrl_busy_in) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!ctrl_busy_in) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      lat_addr       <= '0;
      lat_type       <= TYPE_IMEM_READ;
      lat_wdata      <= '0;
      ibuf_valid     <= 1'b0;
      ibuf_tag       <= '0;
      ibuf_data      <= '0;
      imem_ack_out   <= 1'b0;
      imem_data_out  <= '0;
      dmem_ack_out   <= 1'b0;
      dmem_rdata_out <= '0;
    end else begin
      imem_ack_out <= 1'b0;
      dmem_ack_out <= 1'b0;

      if (take_dmem) begin
        lat_addr  <= dmem_addr_in;
        lat_wdata <= dmem_wdata_in;
        lat_type  <= dmem_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
      end

      if (take_miss) begin
        lat_addr <= {imem_addr_in[15:1], 1'b0};
        lat_type <= TYPE_IMEM_READ;
      end

      if (take_hit) begin
        imem_ack_out  <= 1'b1;
        imem_data_out <= ibuf_data;
      end

      if (capture) begin
        case (lat_type)
          TYPE_IMEM_READ: begin
            imem_data_out <= ctrl_flash_data_in;
            imem_ack_out  <= 1'b1;
            ibuf_valid    <= 1'b1;
            ibuf_tag      <= lat_addr[15:1];
            ibuf_data     <= ctrl_flash_data_in;
          end
          TYPE_DMEM_READ: begin
            dmem_rdata_out <= ctrl_psram_data_in;
            dmem_ack_out   <= 1'b1;
          end
          default: begin
            dmem_ack_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;
  import mem_request_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;  // 0: buffered instance, 1: IBUF_EN=0 instance
  logic        imem_req = 1'b0;
  logic [15:0] imem_addr = '0;
  logic        dmem_req = 1'b0;
  logic        dmem_we = 1'b0;
  logic [15:0] dmem_addr = '0;
  logic [7:0]  dmem_wdata = '0;

  logic        busy;
  logic [15:0] flash_d;
  logic [7:0]  psram_d;

  logic        iack0, iack1, dack0, dack1, av0, av1;
  logic [15:0] idata0, idata1, caddr0, caddr1;
  logic [7:0]  drdata0, drdata1, cw0, cw1;
  mem_type_t   ct0, ct1;

  logic        m_iack, m_dack, m_av;
  logic [15:0] m_idata, m_addr;
  logic [7:0]  m_drdata, m_wdata;
  mem_type_t   m_type;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_request_arbiter #(.IBUF_EN(1)) dut0 (
    .clk_in(clk), .reset_in(reset),
    .imem_req_in(imem_req & ~sel), .imem_addr_in(imem_addr),
    .imem_ack_out(iack0), .imem_data_out(idata0),
    .dmem_req_in(dmem_req & ~sel), .dmem_we_in(dmem_we),
    .dmem_addr_in(dmem_addr), .dmem_wdata_in(dmem_wdata),
    .dmem_ack_out(dack0), .dmem_rdata_out(drdata0),
    .ctrl_addr_out(caddr0), .ctrl_addr_valid_out(av0),
    .ctrl_mem_type_out(ct0), .ctrl_wdata_out(cw0),
    .ctrl_flash_data_in(flash_d), .ctrl_psram_data_in(psram_d),
    .ctrl_busy_in(busy)
  );

  mem_request_arbiter #(.IBUF_EN(0)) dut1 (
    .clk_in(clk), .reset_in(reset),
    .imem_req_in(imem_req & sel), .imem_addr_in(imem_addr),
    .imem_ack_out(iack1), .imem_data_out(idata1),
    .dmem_req_in(dmem_req & sel), .dmem_we_in(dmem_we),
    .dmem_addr_in(dmem_addr), .dmem_wdata_in(dmem_wdata),
    .dmem_ack_out(dack1), .dmem_rdata_out(drdata1),
    .ctrl_addr_out(caddr1), .ctrl_addr_valid_out(av1),
    .ctrl_mem_type_out(ct1), .ctrl_wdata_out(cw1),
    .ctrl_flash_data_in(flash_d), .ctrl_psram_data_in(psram_d),
    .ctrl_busy_in(busy)
  );

  assign m_iack   = sel ? iack1   : iack0;
  assign m_dack   = sel ? dack1   : dack0;
  assign m_av     = sel ? av1     : av0;
  assign m_idata  = sel ? idata1  : idata0;
  assign m_drdata = sel ? drdata1 : drdata0;
  assign m_addr   = sel ? caddr1  : caddr0;
  assign m_wdata  = sel ? cw1     : cw0;
  assign m_type   = sel ? ct1     : ct0;

  // ---------------- SPI controller model ----------------
  logic [7:0]  psram [0:65535];
  logic        pend;
  int          cnt;
  logic [15:0] ma;
  mem_type_t   mt;
  logic [7:0]  mw;

  function automatic logic [15:0] flash_rom(input logic [15:0] a);
    case (a)
      16'h001E: flash_rom = 16'hA55A;
      16'h0020: flash_rom = 16'h1357;
      16'h0040: flash_rom = 16'hBEEF;
      16'h0100: flash_rom = 16'hC0DE;
      default:  flash_rom = 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      pend    <= 1'b0;
      cnt     <= 0;
      flash_d <= '0;
      psram_d <= '0;
    end else if (pend) begin
      if (cnt == 0) begin
        busy <= 1'b0;
        pend <= 1'b0;
        case (mt)
          TYPE_IMEM_READ:  flash_d <= flash_rom(ma);
          TYPE_DMEM_READ:  psram_d <= psram[ma];
          default:         psram[ma] <= mw;
        endcase
      end else begin
        cnt <= cnt - 1;
      end
    end else if (m_av) begin
      pend <= 1'b1;
      busy <= 1'b1;
      cnt  <= 3;
      ma   <= m_addr;
      mt   <= m_type;
      mw   <= m_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  localparam int K_SPI = 0, K_IACK = 1, K_DACK_R = 2, K_DACK_W = 3;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    mem_type_t   typ;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  task automatic push(input int k, input logic [15:0] a, input mem_type_t t, input logic [15:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.typ = t; e.data = d;
    q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [15:0] a, input mem_type_t t, input logic [15:0] d);
    exp_t e;
    bit bad;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h type=%0d data=%h, required none", k, a, t, d);
    end else begin
      e = q.pop_front();
      bad = 1'b0;
      if (k == K_DACK_R) begin
        if (e.kind == K_DACK_R) bad = (d != e.data);
        else bad = (e.kind != K_DACK_W);
      end else if (k == K_SPI) begin
        bad = (e.kind != K_SPI) || (a != e.addr) || (t != e.typ) ||
              ((t == TYPE_DMEM_WRITE) && (d != e.data));
      end else begin
        bad = (e.kind != k) || (d != e.data);
      end
      if (bad)
        begin
          failures++;
          $display("FAIL event_mismatch: got kind=%0d addr=%h type=%0d data=%h, required kind=%0d addr=%h type=%0d data=%h",
                   k, a, t, d, e.kind, e.addr, e.typ, e.data);
        end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_iack || m_dack) begin
        checks++;
        if (m_iack && m_dack) begin
          failures++;
          $display("FAIL ack_overlap: imem_ack=%b dmem_ack=%b, required at most one", m_iack, m_dack);
        end
      end
      if (m_av)   observe(K_SPI, m_addr, m_type, {8'h00, m_wdata});
      if (m_iack) observe(K_IACK, 16'h0, TYPE_IMEM_READ, m_idata);
      if (m_dack) observe(K_DACK_R, 16'h0, TYPE_IMEM_READ, {8'h00, m_drdata});
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic serve(input bit do_i, input logic [15:0] ia, input bit do_d, input bit we,
                       input logic [15:0] da, input logic [7:0] wd, output int ilat);
    int  n;
    bit  idone, ddone;
    @(posedge clk); #1;
    imem_addr = ia; dmem_addr = da; dmem_we = we; dmem_wdata = wd;
    imem_req = do_i; dmem_req = do_d;
    idone = !do_i; ddone = !do_d; ilat = 0; n = 0;
    while (!(idone && ddone) && n < 300) begin
      @(negedge clk); n++;
      if (m_iack && !idone) begin idone = 1'b1; ilat = n; end
      if (m_dack && !ddone) ddone = 1'b1;
      @(posedge clk); #1;
      if (idone) imem_req = 1'b0;
      if (ddone) dmem_req = 1'b0;
    end
    checks++;
    if (!(idone && ddone)) begin
      failures++;
      $display("FAIL serve_timeout: imem_done=%b dmem_done=%b, required both done", idone, ddone);
      imem_req = 1'b0; dmem_req = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_imem_ack"},  {15'h0, iack0}, 16'h0);
    chk({tag, "_dmem_ack"},  {15'h0, dack0}, 16'h0);
    chk({tag, "_addr_valid"}, {15'h0, av0}, 16'h0);
    chk({tag, "_ctrl_addr"}, caddr0, 16'h0);
    chk({tag, "_ctrl_type"}, {14'h0, ct0}, {14'h0, TYPE_IMEM_READ});
    chk({tag, "_ctrl_wdata"}, {8'h0, cw0}, 16'h0);
    chk({tag, "_imem_data"}, idata0, 16'h0);
    chk({tag, "_dmem_rdata"}, {8'h0, drdata0}, 16'h0);
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold fetch of odd address 0x001F -> word 0x001E from SPI
    push(K_SPI, 16'h001E, TYPE_IMEM_READ, 16'h0);
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hA55A);
    serve(1, 16'h001F, 0, 0, 16'h0, 8'h0, lat);
    chk("cold_fetch_data", idata0, 16'hA55A);

    // Repeat fetch hits the buffer: ack on the next cycle, no SPI pulse
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hA55A);
    serve(1, 16'h001E, 0, 0, 16'h0, 8'h0, lat);
    chk("hit_latency", lat[15:0], 16'd2);

    // Different word misses
    push(K_SPI, 16'h0020, TYPE_IMEM_READ, 16'h0);
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'h1357);
    serve(1, 16'h0020, 0, 0, 16'h0, 8'h0, lat);

    // DMEM write then read back
    push(K_SPI, 16'h1234, TYPE_DMEM_WRITE, 16'h005C);
    push(K_DACK_W, 16'h0, TYPE_IMEM_READ, 16'h0);
    serve(0, 16'h0, 1, 1, 16'h1234, 8'h5C, lat);
    push(K_SPI, 16'h1234, TYPE_DMEM_READ, 16'h0);
    push(K_DACK_R, 16'h0, TYPE_IMEM_READ, 16'h005C);
    serve(0, 16'h0, 1, 0, 16'h1234, 8'h00, lat);
    chk("dmem_rdata_held", {8'h0, drdata0}, 16'h005C);

    // Simultaneous requests: DMEM first, IMEM miss afterwards
    push(K_SPI, 16'h1234, TYPE_DMEM_READ, 16'h0);
    push(K_DACK_R, 16'h0, TYPE_IMEM_READ, 16'h005C);
    push(K_SPI, 16'h0040, TYPE_IMEM_READ, 16'h0);
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hBEEF);
    serve(1, 16'h0040, 1, 0, 16'h1234, 8'h00, lat);

    // Buffer now holds 0x0040
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hBEEF);
    serve(1, 16'h0040, 0, 0, 16'h0, 8'h0, lat);
    chk("hit2_latency", lat[15:0], 16'd2);

    // Reset while waiting for fetch data of 0x0100
    push(K_SPI, 16'h0100, TYPE_IMEM_READ, 16'h0);
    @(posedge clk); #1;
    imem_addr = 16'h0100; imem_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!busy && n < 50);
    chk("busy_seen", {15'h0, busy}, 16'h1);
    @(posedge clk); #1;
    reset = 1'b1; imem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");
    repeat (10) @(posedge clk);

    // Buffer was invalidated by reset: 0x0040 misses
    push(K_SPI, 16'h0040, TYPE_IMEM_READ, 16'h0);
    push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hBEEF);
    serve(1, 16'h0040, 0, 0, 16'h0, 8'h0, lat);

    // IBUF_EN=0 instance: two fetches, two SPI transactions
    @(posedge clk); #1 sel = 1'b1;
    repeat (2) @(posedge clk);
    repeat (2) begin
      push(K_SPI, 16'h0040, TYPE_IMEM_READ, 16'h0);
      push(K_IACK, 16'h0, TYPE_IMEM_READ, 16'hBEEF);
      serve(1, 16'h0040, 0, 0, 16'h0, 8'h0, lat);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
